// File: rtl/polar_fir_mul_pkg.sv
// Shared widths, latency and in-flight bookkeeping types for the polar FIR
// multiplier scheduler.
package polar_fir_mul_pkg;

  localparam int A_W     = 24;
  localparam int B_W     = 12;
  localparam int P_W     = A_W + B_W;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 3;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_Q = 1'b1
  } src_t;

  typedef struct packed {
    logic              vld;
    src_t              src;
    logic [TAG_W-1:0]  tag;
  } inflight_t;

endpackage

// File: rtl/polar_fir_mul_tag_pipe.sv
// Shift register that shadows the multiplier pipeline, carrying each
// product's valid, source channel and tag until the product emerges.
module polar_fir_mul_tag_pipe
  import polar_fir_mul_pkg::*;
#(
  parameter int DEPTH = MUL_LAT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en,
  input  logic      clr,
  input  inflight_t din,
  output inflight_t dout,
  output logic      any_vld
);

  inflight_t stage_r [DEPTH];

  // Stage shift on enabled edges; clear drops only the valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= '0;
      end
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k].vld <= 1'b0;
      end
    end else if (en) begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  // OR of all stage valids for the busy indication.
  always_comb begin
    any_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_vld = any_vld | stage_r[k].vld;
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/polar_fir_mul_sched.sv
// Round-robin issue scheduler sharing one pipelined multiplier between the
// I and Q MAC sequencers, with a stallable valid/ready result port.
module polar_fir_mul_sched
  import polar_fir_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [1:0]           req_vld,
  output logic [1:0]           req_rdy,
  input  logic [2*A_W-1:0]     req_a,
  input  logic [2*B_W-1:0]     req_b,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic                 mul_ce,
  output logic [A_W-1:0]       mul_din0,
  output logic [B_W-1:0]       mul_din1,
  input  logic [P_W-1:0]       mul_dout,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [P_W-1:0]       res_p,
  output logic                 res_src,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 busy
);

  // rr_r is the channel preferred on contention; it resets to I.
  src_t             rr_r;
  logic             grant_vld_s;
  src_t             grant_src_s;
  logic [A_W-1:0]   sel_a_s;
  logic [B_W-1:0]   sel_b_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic [A_W-1:0]   hold_a_r;
  logic [B_W-1:0]   hold_b_r;
  inflight_t        pipe_in_s;
  inflight_t        tail_s;
  logic             pipe_any_s;

  assign mul_ce = reset_n & (~res_vld | res_rdy);

  // Grant selection: none while stalled or flushing.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_src_s = SRC_I;
    if (mul_ce && !flush) begin
      case (req_vld)
        2'b01:   begin grant_vld_s = 1'b1; grant_src_s = SRC_I; end
        2'b10:   begin grant_vld_s = 1'b1; grant_src_s = SRC_Q; end
        2'b11:   begin grant_vld_s = 1'b1; grant_src_s = rr_r;  end
        default: begin grant_vld_s = 1'b0; grant_src_s = SRC_I; end
      endcase
    end else begin
      grant_vld_s = 1'b0;
      grant_src_s = SRC_I;
    end
  end

  // Operand/tag mux and handshake outputs; operands hold when idle.
  always_comb begin
    sel_a_s   = req_a[A_W-1:0];
    sel_b_s   = req_b[B_W-1:0];
    sel_tag_s = req_tag[TAG_W-1:0];
    req_rdy   = 2'b00;
    mul_din0  = hold_a_r;
    mul_din1  = hold_b_r;
    if (grant_src_s == SRC_Q) begin
      sel_a_s   = req_a[2*A_W-1:A_W];
      sel_b_s   = req_b[2*B_W-1:B_W];
      sel_tag_s = req_tag[2*TAG_W-1:TAG_W];
    end else begin
      sel_a_s   = req_a[A_W-1:0];
      sel_b_s   = req_b[B_W-1:0];
      sel_tag_s = req_tag[TAG_W-1:0];
    end
    if (grant_vld_s) begin
      req_rdy  = (grant_src_s == SRC_Q) ? 2'b10 : 2'b01;
      mul_din0 = sel_a_s;
      mul_din1 = sel_b_s;
    end else begin
      req_rdy  = 2'b00;
      mul_din0 = hold_a_r;
      mul_din1 = hold_b_r;
    end
  end

  // Arbiter state and last-issued operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_r     <= SRC_I;
      hold_a_r <= {A_W{1'b0}};
      hold_b_r <= {B_W{1'b0}};
    end else if (grant_vld_s) begin
      rr_r     <= (grant_src_s == SRC_I) ? SRC_Q : SRC_I;
      hold_a_r <= sel_a_s;
      hold_b_r <= sel_b_s;
    end
  end

  // Stage-0 entry for the tag pipe.
  always_comb begin
    pipe_in_s     = '0;
    pipe_in_s.vld = grant_vld_s;
    pipe_in_s.src = grant_src_s;
    pipe_in_s.tag = sel_tag_s;
  end

  polar_fir_mul_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mul_ce),
    .clr     (flush),
    .din     (pipe_in_s),
    .dout    (tail_s),
    .any_vld (pipe_any_s)
  );

  // Result register; payload only moves when a real product arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_vld <= 1'b0;
      res_p   <= {P_W{1'b0}};
      res_src <= 1'b0;
      res_tag <= {TAG_W{1'b0}};
    end else if (flush) begin
      res_vld <= 1'b0;
    end else if (mul_ce) begin
      res_vld <= tail_s.vld;
      if (tail_s.vld) begin
        res_p   <= mul_dout;
        res_src <= tail_s.src;
        res_tag <= tail_s.tag;
      end
    end
  end

  assign busy = pipe_any_s | res_vld;

endmodule

// File: tb/tb_polar_fir_mul_sched.sv
// Self-checking bench: a queue-based product model checked every cycle plus
// directed vectors with hand-computed results.
module tb_polar_fir_mul_sched;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n, flush, res_rdy;
  logic [1:0]  req_vld, req_rdy;
  logic [47:0] req_a;
  logic [23:0] req_b;
  logic [7:0]  req_tag;
  logic        mul_ce;
  logic [23:0] mul_din0;
  logic [11:0] mul_din1;
  logic [35:0] mul_dout;
  logic        res_vld, res_src, busy;
  logic [35:0] res_p;
  logic [3:0]  res_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  polar_fir_mul_sched dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_p(res_p), .res_src(res_src),
    .res_tag(res_tag), .busy(busy)
  );

  function automatic logic signed [35:0] prod(input logic [23:0] a, input logic [11:0] b);
    logic signed [35:0] ea, eb;
    ea = {{12{a[23]}}, a};
    eb = {24'd0, b};
    return ea * eb;
  endfunction

  // Behavioural 3-stage ce-gated multiplier.
  logic signed [35:0] mp0 = 36'sd0, mp1 = 36'sd0, mp2 = 36'sd0;
  always @(posedge clk) begin
    if (mul_ce) begin
      mp0 <= prod(mul_din0, mul_din1);
      mp1 <= mp0;
      mp2 <= mp1;
    end
  end
  assign mul_dout = mp2;

  typedef struct {
    logic [35:0] p;
    logic        src;
    logic [3:0]  tag;
    int          stamp;
  } ent_t;

  ent_t        q[$];
  int          ce_cnt = 0;
  logic        m_vld = 1'b0;
  logic [35:0] m_p = 36'd0;
  logic        m_src = 1'b0;
  logic [3:0]  m_tag = 4'd0;
  logic        pref = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check DUT against the model, then advance the model by the coming edge.
  task automatic model_cycle();
    logic        exp_ce, g_vld, g_src;
    logic [23:0] a_sel;
    logic [11:0] b_sel;
    logic [3:0]  t_sel;
    ent_t        e;
    if (!reset_n) begin
      q.delete();
      m_vld = 1'b0; m_p = 36'd0; m_src = 1'b0; m_tag = 4'd0; pref = 1'b0;
    end
    exp_ce = reset_n && (!m_vld || res_rdy);
    g_vld = 1'b0;
    g_src = 1'b0;
    if (exp_ce && !flush) begin
      if (req_vld == 2'b11) begin g_vld = 1'b1; g_src = pref; end
      else if (req_vld[0]) begin g_vld = 1'b1; g_src = 1'b0; end
      else if (req_vld[1]) begin g_vld = 1'b1; g_src = 1'b1; end
    end
    a_sel = g_src ? req_a[47:24] : req_a[23:0];
    b_sel = g_src ? req_b[23:12] : req_b[11:0];
    t_sel = g_src ? req_tag[7:4] : req_tag[3:0];
    chk("mul_ce", mul_ce, exp_ce);
    chk("req_rdy", req_rdy, g_vld ? (g_src ? 2'b10 : 2'b01) : 2'b00);
    chk("res_vld", res_vld, m_vld);
    chk("busy", busy, (q.size() != 0) || m_vld);
    if (g_vld) begin
      chk("mul_din0", mul_din0, a_sel);
      chk("mul_din1", mul_din1, b_sel);
    end
    if (m_vld) begin
      chk("res_p", res_p, m_p);
      chk("res_src", res_src, m_src);
      chk("res_tag", res_tag, m_tag);
    end
    if (reset_n) begin
      if (flush) begin
        q.delete();
        m_vld = 1'b0;
      end else if (exp_ce) begin
        if (q.size() > 0 && q[0].stamp + MUL_LAT == ce_cnt) begin
          e = q.pop_front();
          m_vld = 1'b1; m_p = e.p; m_src = e.src; m_tag = e.tag;
        end else begin
          m_vld = 1'b0;
        end
        if (g_vld) begin
          e.p = prod(a_sel, b_sel); e.src = g_src; e.tag = t_sel; e.stamp = ce_cnt;
          q.push_back(e);
          pref = ~g_src;
        end
        ce_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; res_rdy = 1'b1;
    req_vld = 2'b00; req_a = 48'd0; req_b = 24'd0; req_tag = 8'd0;
    repeat (3) tick();
    chk("rst_res_vld", res_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_p", res_p, 36'd0);
    chk("rst_req_rdy", req_rdy, 2'b00);
    reset_n = 1'b1;
    tick();

    // 1: single I request
    req_vld = 2'b01; req_a = {24'd0, 24'hFFFFFB}; req_b = {12'd0, 12'd100}; req_tag = {4'd0, 4'd3};
    #1 chk("t1_rdy", req_rdy, 2'b01);
    tick();
    req_vld = 2'b00;
    repeat (3) tick();
    chk("t1_vld", res_vld, 1'b1);
    chk("t1_p", res_p, 36'hFFFFFFE0C);
    chk("t1_src", res_src, 1'b0);
    chk("t1_tag", res_tag, 4'd3);
    tick();

    // 2: both requesting, alternating grants starting with Q
    req_vld = 2'b11; req_a = {24'd1000, 24'd2000}; req_b = {12'd3, 12'd7};
    for (int i = 0; i < 8; i++) begin
      req_tag = {4'(i + 8), 4'(i)};
      #1 chk("t2_grant", req_rdy, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req_vld = 2'b00;
    repeat (5) tick();

    // 3: backpressure for 5 cycles
    req_vld = 2'b11; req_a = {24'h123456, 24'hFEDCBA}; req_b = {12'hABC, 12'h321}; req_tag = 8'h5A;
    repeat (4) tick();
    res_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ce", mul_ce, 1'b0);
      chk("t3_rdy", req_rdy, 2'b00);
      chk("t3_hold", res_p, m_p);
      tick();
    end
    res_rdy = 1'b1; req_vld = 2'b00;
    repeat (6) tick();

    // 4: operand extremes
    req_vld = 2'b01; req_a = {24'd0, 24'h800000}; req_b = {12'd0, 12'hFFF}; req_tag = {4'd0, 4'd5};
    tick();
    req_vld = 2'b10; req_a = {24'h7FFFFF, 24'd0}; req_b = {12'hFFF, 12'd0}; req_tag = {4'd6, 4'd0};
    tick();
    req_vld = 2'b00;
    repeat (2) tick();
    chk("t4_min", res_p, -36'sd34351349760);
    tick();
    chk("t4_max", res_p, 36'sd34351345665);
    chk("t4_src", res_src, 1'b1);
    chk("t4_tag", res_tag, 4'd6);
    repeat (2) tick();

    // 5: flush with products in flight
    req_vld = 2'b11; req_a = {24'd11, 24'd22}; req_b = {12'd5, 12'd6}; req_tag = 8'hAB;
    repeat (5) tick();
    flush = 1'b1;
    #1 chk("t5_flush_rdy", req_rdy, 2'b00);
    tick();
    flush = 1'b0; req_vld = 2'b00;
    #1;
    chk("t5_res_vld", res_vld, 1'b0);
    chk("t5_busy", busy, 1'b0);
    req_vld = 2'b01; req_a = {24'd0, 24'd7}; req_b = {12'd0, 12'd9}; req_tag = {4'd0, 4'd9};
    tick();
    req_vld = 2'b00;
    repeat (3) tick();
    chk("t5_new_vld", res_vld, 1'b1);
    chk("t5_new_p", res_p, 36'd63);
    chk("t5_new_tag", res_tag, 4'd9);
    tick();
    chk("t5_no_stale", res_vld, 1'b0);
    chk("t5_idle", busy, 1'b0);

    // 6: reset mid-stream
    req_vld = 2'b11; req_a = {24'd100, 24'd200}; req_b = {12'd2, 12'd3}; req_tag = 8'h12;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_res_vld", res_vld, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_req_rdy", req_rdy, 2'b00);
    chk("t6_res_p", res_p, 36'd0);
    chk("t6_din0", mul_din0, 24'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    #1 chk("t6_first_grant", req_rdy, 2'b01);
    repeat (6) tick();
    req_vld = 2'b00;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
